// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Command sequencer between the UART ASCII-hex receiver word stream and
//   the SATA host datapath. Each tlast-delimited line is one packet: a
//   header word {opcode[31:28], -, index[23:16], count[15:0]} followed by
//   payload words. FIS payloads are forwarded to the SATA transmit stream,
//   CFG payloads become a single config-register write, and malformed
//   packets are drained to end of line. A per-packet status word
//   {8'hA5, opcode, code, fwd_count} is produced at end of every packet.
//
//   Optional feature macro: UART_CMD_CTRL_STATUS_EN
//     defined   : status register/stream present, S_STAT stalls while the
//                 previous status word is still pending.
//     undefined : o_stat_* tied to 0, i_stat_tready ignored, S_STAT is
//                 always a single cycle.
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   i_tvalid/o_tready/i_tlast/i_tdata        command stream in
//   o_fis_tvalid/i_fis_tready/o_fis_tlast/o_fis_tdata  FIS stream out
//   o_cfg_we/o_cfg_addr/o_cfg_wdata          config write strobe
//   o_stat_tvalid/i_stat_tready/o_stat_tdata status stream out

module uart_cmd_ctrl #(
    parameter int MAX_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_tvalid,
    output logic        o_tready,
    input  logic        i_tlast,
    input  logic [31:0] i_tdata,
    output logic        o_fis_tvalid,
    input  logic        i_fis_tready,
    output logic        o_fis_tlast,
    output logic [31:0] o_fis_tdata,
    output logic        o_cfg_we,
    output logic [7:0]  o_cfg_addr,
    output logic [31:0] o_cfg_wdata,
    output logic        o_stat_tvalid,
    input  logic        i_stat_tready,
    output logic [31:0] o_stat_tdata
);

    typedef enum logic [2:0] {
        S_HDR,
        S_FIS,
        S_CFG,
        S_DROP,
        S_STAT
    } state_t;

    localparam logic [3:0] OPC_FIS   = 4'd1;
    localparam logic [3:0] OPC_CFG   = 4'd2;

    localparam logic [3:0] CODE_OK    = 4'd0;
    localparam logic [3:0] CODE_OPC   = 4'd1;
    localparam logic [3:0] CODE_LEN   = 4'd2;
    localparam logic [3:0] CODE_SHORT = 4'd3;
    localparam logic [3:0] CODE_LONG  = 4'd4;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_reg;
    logic        run_reg;
    logic [3:0]  opcode_reg;
    logic [7:0]  index_reg;
    logic [15:0] len_reg;
    logic [15:0] cnt_reg;
    logic [3:0]  code_reg;

    logic        fis_tvalid_reg;
    logic        fis_tlast_reg;
    logic [31:0] fis_tdata_reg;
    logic        cfg_we_reg;
    logic [7:0]  cfg_addr_reg;
    logic [31:0] cfg_wdata_reg;

    logic        ready;
    logic        accept;
    logic [15:0] cnt_inc;
    logic        last_word;
    logic [3:0]  hdr_op;
    logic [15:0] hdr_n;
    logic [3:0]  hdr_code;
    state_t      hdr_next;
    logic        stat_free;
    logic [31:0] stat_word;

    // Ready is held low for the first cycle after reset so that every
    // output, including o_tready, reads 0 while reset is applied.
    always_comb begin
        ready = 1'b0;
        case (state_reg)
            S_HDR:   ready = 1'b1;
            S_FIS:   ready = ~fis_tvalid_reg | i_fis_tready;
            S_CFG:   ready = 1'b1;
            S_DROP:  ready = 1'b1;
            S_STAT:  ready = 1'b0;
            default: ready = 1'b0;
        endcase
    end

    assign o_tready  = ready & run_reg;
    assign accept    = i_tvalid & o_tready;
    assign cnt_inc   = cnt_reg + 16'd1;
    assign last_word = (cnt_inc == len_reg);
    assign hdr_op    = i_tdata[31:28];
    assign hdr_n     = i_tdata[15:0];
    assign stat_word = {8'hA5, opcode_reg, code_reg, cnt_reg};

    // Header decode. Length errors take precedence over a premature tlast;
    // a header that already ends the line skips the drain state.
    always_comb begin
        hdr_code = CODE_OK;
        hdr_next = S_DROP;
        case (hdr_op)
            OPC_FIS: begin
                if (hdr_n == 16'd0 || {1'b0, hdr_n} > MAX_W)
                    hdr_code = CODE_LEN;
                else if (i_tlast)
                    hdr_code = CODE_SHORT;
                else
                    hdr_next = S_FIS;
            end
            OPC_CFG: begin
                if (hdr_n != 16'd1)
                    hdr_code = CODE_LEN;
                else if (i_tlast)
                    hdr_code = CODE_SHORT;
                else
                    hdr_next = S_CFG;
            end
            default: hdr_code = CODE_OPC;
        endcase
        if (hdr_code != CODE_OK)
            hdr_next = i_tlast ? S_STAT : S_DROP;
    end

`ifdef UART_CMD_CTRL_STATUS_EN
    logic        stat_tvalid_reg;
    logic [31:0] stat_tdata_reg;

    assign stat_free     = ~stat_tvalid_reg | i_stat_tready;
    assign o_stat_tvalid = stat_tvalid_reg;
    assign o_stat_tdata  = stat_tdata_reg;
`else
    logic [32:0] unused_stat;

    assign stat_free     = 1'b1;
    assign o_stat_tvalid = 1'b0;
    assign o_stat_tdata  = 32'd0;
    assign unused_stat   = {i_stat_tready, stat_word};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= S_HDR;
            run_reg        <= 1'b0;
            opcode_reg     <= 4'd0;
            index_reg      <= 8'd0;
            len_reg        <= 16'd0;
            cnt_reg        <= 16'd0;
            code_reg       <= CODE_OK;
            fis_tvalid_reg <= 1'b0;
            fis_tlast_reg  <= 1'b0;
            fis_tdata_reg  <= 32'd0;
            cfg_we_reg     <= 1'b0;
            cfg_addr_reg   <= 8'd0;
            cfg_wdata_reg  <= 32'd0;
`ifdef UART_CMD_CTRL_STATUS_EN
            stat_tvalid_reg <= 1'b0;
            stat_tdata_reg  <= 32'd0;
`endif
        end else begin
            run_reg    <= 1'b1;
            cfg_we_reg <= 1'b0;

            // Output stage drains independently of the FSM; a new load in
            // S_FIS below overrides this clear in the same cycle.
            if (fis_tvalid_reg && i_fis_tready) begin
                fis_tvalid_reg <= 1'b0;
                fis_tlast_reg  <= 1'b0;
            end
`ifdef UART_CMD_CTRL_STATUS_EN
            if (stat_tvalid_reg && i_stat_tready)
                stat_tvalid_reg <= 1'b0;
`endif

            case (state_reg)
                S_HDR: begin
                    if (accept) begin
                        opcode_reg <= hdr_op;
                        index_reg  <= i_tdata[23:16];
                        len_reg    <= hdr_n;
                        cnt_reg    <= 16'd0;
                        code_reg   <= hdr_code;
                        state_reg  <= hdr_next;
                    end
                end
                S_FIS: begin
                    if (accept) begin
                        fis_tvalid_reg <= 1'b1;
                        fis_tdata_reg  <= i_tdata;
                        fis_tlast_reg  <= last_word | i_tlast;
                        cnt_reg        <= cnt_inc;
                        if (last_word) begin
                            code_reg  <= i_tlast ? CODE_OK : CODE_LONG;
                            state_reg <= i_tlast ? S_STAT : S_DROP;
                        end else if (i_tlast) begin
                            code_reg  <= CODE_SHORT;
                            state_reg <= S_STAT;
                        end
                    end
                end
                S_CFG: begin
                    if (accept) begin
                        cfg_we_reg    <= 1'b1;
                        cfg_addr_reg  <= index_reg;
                        cfg_wdata_reg <= i_tdata;
                        code_reg      <= i_tlast ? CODE_OK : CODE_LONG;
                        state_reg     <= i_tlast ? S_STAT : S_DROP;
                    end
                end
                S_DROP: begin
                    if (accept && i_tlast)
                        state_reg <= S_STAT;
                end
                S_STAT: begin
                    // Wait here (input stalled) while a previous status word
                    // is still unaccepted.
                    if (stat_free) begin
`ifdef UART_CMD_CTRL_STATUS_EN
                        stat_tvalid_reg <= 1'b1;
                        stat_tdata_reg  <= stat_word;
`endif
                        state_reg <= S_HDR;
                    end
                end
                default: state_reg <= S_HDR;
            endcase
        end
    end

    assign o_fis_tvalid = fis_tvalid_reg;
    assign o_fis_tlast  = fis_tlast_reg;
    assign o_fis_tdata  = fis_tdata_reg;
    assign o_cfg_we     = cfg_we_reg;
    assign o_cfg_addr   = cfg_addr_reg;
    assign o_cfg_wdata  = cfg_wdata_reg;

endmodule
